// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode encodings, FSM states and iteration count for the multiply/divide unit
package mdu_pkg;
  localparam int MDU_ITER = 32;
  typedef enum logic [1:0] {MDU_MULT = 2'b00, MDU_MULTU = 2'b01, MDU_DIV = 2'b10, MDU_DIVU = 2'b11} mdu_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration, shift-add multiply or restoring divide
module mdu_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  input  logic           is_div,
  output logic [2*W-1:0] nxt
);
  logic [2*W:0] ext;
  logic [W:0]   sum;
  logic [W-1:0] r;
  logic         ge;
  always_comb begin
    ext = {1'b0, acc};
    sum = ext[2*W:W] + {1'b0, opnd};
    ge  = ext[2*W:W-1] >= (W+2)'(opnd);
    r   = ext[2*W-2:W-1] - opnd;
    nxt = is_div ? {ge ? r : ext[2*W-2:W-1], ext[W-2:0], ge}
                 : {ext[0] ? sum : ext[2*W:W], ext[W-1:1]};
  end
endmodule

// File: rtl/mdu32.sv
// mdu32: iterative multiply/divide unit with architectural HI/LO and start/busy/done handshake
module mdu32 import mdu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int ITER  = MDU_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Read_data_1,
  input  logic [WIDTH-1:0] Read_data_2,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(ITER);
  state_e             state, state_n;
  mdu_op_e            op_q;
  logic               sign_a, sign_b, take, idle_like, sgn, fix_div;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   raw_a, opnd, mag_a, mag_b, quo, rem;
  logic [2*WIDTH-1:0] acc, acc_n, prod;
  always_comb begin
    idle_like = state == IDLE || state == DONE;
    take      = start && idle_like;
    sgn       = op == MDU_MULT || op == MDU_DIV;
    mag_a     = sgn && Read_data_1[WIDTH-1] ? -Read_data_1 : Read_data_1;
    mag_b     = sgn && Read_data_2[WIDTH-1] ? -Read_data_2 : Read_data_2;
    fix_div   = op_q == MDU_DIV || op_q == MDU_DIVU;
    prod      = sign_a ^ sign_b ? -acc : acc;
    quo       = sign_a ^ sign_b ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem       = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    state_n   = state == CALC ? (cnt == CW'(ITER-1) ? FIX : CALC)
              : state == FIX  ? DONE
              : take          ? CALC : IDLE;
    busy      = state == CALC || state == FIX;
    done      = state == DONE;
  end
  mdu_step #(.W(WIDTH)) u_step (.acc(acc), .opnd(opnd), .is_div(fix_div), .nxt(acc_n));
  always_ff @(posedge clock)
    state <= !reset ? IDLE : state_n;
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt      <= '0;
      HI       <= '0;
      LO       <= '0;
      div_zero <= 1'b0;
    end else if (take) begin
      op_q     <= mdu_op_e'(op);
      sign_a   <= sgn && Read_data_1[WIDTH-1];
      sign_b   <= sgn && Read_data_2[WIDTH-1];
      raw_a    <= Read_data_1;
      opnd     <= op[1] ? mag_b : mag_a;
      acc      <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
      cnt      <= '0;
      div_zero <= 1'b0;
    end else if (state == CALC) begin
      acc <= acc_n;
      cnt <= cnt + CW'(1);
    end else if (state == FIX) begin
      if (fix_div && opnd == '0) begin
        LO       <= '1;
        HI       <= raw_a;
        div_zero <= 1'b1;
      end else if (fix_div) begin
        LO <= quo;
        HI <= rem;
      end else
        {HI, LO} <= prod;
    end else if (hilo_we && idle_like) begin
      if (hilo_sel) HI <= hilo_wdata;
      else LO <= hilo_wdata;
    end
  end
endmodule
